// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   uart_state_e    : transmitter frame state (idle, start bit, data bits, stop bit)
//   UART_DATA_W     : data bits per frame (8N1 framing)
//   UART_OVERSAMPLE : clk_16x ticks per serial bit
//   UART_BIT_CNT_W  : width of the per-bit tick counter
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_BIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request at or after index ptr, wrapping modulo NUM_REQ.
//   req    : per-requester request bits
//   ptr    : highest-priority index for this decision
//   en     : when low, no grant is issued
//   gnt    : one-hot grant (all-zero when disabled or nothing requested)
//   gnt_id : binary index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        if (en) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = (32'(ptr) + k) % NUM_REQ;
                if (!found && req[idx]) begin
                    found       = 1'b1;
                    gnt[idx]    = 1'b1;
                    gnt_id      = ID_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// One 8N1 UART transmitter shared by NUM_REQ byte sources with round-robin arbitration.
// Bit timing comes from the single-cycle clk_16x enable; each bit lasts 16 ticks.
//   clk       : system clock
//   rst       : synchronous active-high reset, aborts any frame in progress
//   clk_16x   : one-clk enable pulse at 16x the baud rate
//   req_valid : per-requester byte available
//   req_data  : requester i drives bits [i*DATA_W +: DATA_W]
//   req_ready : one-hot acceptance strobe, only while idle (combinational)
//   tx        : serial line, idle high (registered)
//   busy      : frame in progress (registered)
//   grant_id  : index of the last accepted requester (registered)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = UART_DATA_W,
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_16x,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
);

    localparam int unsigned BIT_IDX_W = $clog2(DATA_W);
    localparam logic [UART_BIT_CNT_W-1:0] TICK_LAST = UART_BIT_CNT_W'(UART_OVERSAMPLE - 1);
    localparam logic [BIT_IDX_W-1:0]      BIT_LAST  = BIT_IDX_W'(DATA_W - 1);

    uart_state_e               state_q;
    logic [UART_BIT_CNT_W-1:0] tick_q;
    logic [BIT_IDX_W-1:0]      bit_idx_q;
    logic [DATA_W-1:0]         shift_q;
    logic [ID_W-1:0]           ptr_q;
    logic [ID_W-1:0]           grant_id_q;
    logic                      tx_q;
    logic                      busy_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_id;
    logic               arb_en;
    logic               accept;
    logic               bit_end;
    logic [DATA_W-1:0]  win_data;
    logic [ID_W-1:0]    ptr_nxt;

    // Ready is suppressed while reset is held so nothing is consumed during reset.
    assign arb_en = (state_q == StIdle) && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .en     (arb_en),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    assign req_ready = arb_gnt;
    assign accept    = |arb_gnt;
    assign bit_end   = clk_16x && (tick_q == TICK_LAST);

    // One-hot mux of the winning byte.
    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                win_data = win_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ptr_nxt = arb_id + ID_W'(1);
        if (32'(arb_id) == NUM_REQ - 1) begin
            ptr_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            grant_id_q <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // A tick coinciding with acceptance is dropped by clearing the counter.
                    if (accept) begin
                        shift_q    <= win_data;
                        grant_id_q <= arb_id;
                        ptr_q      <= ptr_nxt;
                        tick_q     <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    if (clk_16x) begin
                        tick_q <= tick_q + 1'b1;
                    end
                    if (bit_end) begin
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (clk_16x) begin
                        tick_q <= tick_q + 1'b1;
                    end
                    if (bit_end) begin
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == BIT_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            // Next bit is shift_q[1] because the shift lands this same edge.
                            tx_q <= shift_q[1];
                        end
                    end
                end
                StStop: begin
                    if (clk_16x) begin
                        tick_q <= tick_q + 1'b1;
                    end
                    if (bit_end) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. A frame-level model predicts the arbitration
// winner, the tx level (from the count of ticks since acceptance) and busy/grant_id.
module tb_uart_tx_arbiter;

    localparam int N = 3;
    localparam int W = 8;
    localparam int FRAME_TICKS = 160;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clk_16x = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx;
    logic           busy;
    logic [1:0]     grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_16x   (clk_16x),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int tick_per = 10;
    int tick_ph  = 0;

    // Reference model: frame position measured in ticks since acceptance.
    int         m_pulses = FRAME_TICKS;
    int         m_ptr    = 0;
    int         m_grant  = 0;
    logic [9:0] m_frame  = '1;
    int         acc_cnt  = 0;

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk: called at a negedge, returns at the next negedge.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        logic [W-1:0] byte_in;
        logic         pulse;
        logic         e_tx;
        int           w;
        clk_16x = (tick_per > 0) && (tick_ph == 0);
        tick_ph = (tick_per > 0) ? (tick_ph + 1) % tick_per : 0;
        pulse   = clk_16x;
        #1;
        exp_rdy = '0;
        w       = -1;
        if (!rst && m_pulses >= FRAME_TICKS) begin
            w = rr_pick(req_valid, m_ptr);
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        byte_in = (w >= 0) ? req_data[w*W +: W] : '0;
        @(posedge clk);
        if (rst) begin
            m_pulses = FRAME_TICKS;
            m_ptr    = 0;
            m_grant  = 0;
        end else if (w >= 0) begin
            m_frame  = {1'b1, byte_in, 1'b0};
            m_pulses = 0;
            m_grant  = w;
            m_ptr    = (w + 1) % N;
            acc_cnt++;
        end else if (m_pulses < FRAME_TICKS && pulse) begin
            m_pulses++;
        end
        @(negedge clk);
        e_tx = (m_pulses >= FRAME_TICKS) ? 1'b1 : m_frame[m_pulses/16];
        check("tx", 32'(tx), 32'(e_tx));
        check("busy", 32'(busy), 32'(m_pulses < FRAME_TICKS));
        check("grant_id", 32'(grant_id), 32'(m_grant));
    endtask

    task automatic wait_accept(input int target, input int bound);
        int n = 0;
        while (acc_cnt < target && n < bound) begin
            cycle();
            n++;
        end
        check("accept_timeout", 32'(acc_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (m_pulses < FRAME_TICKS && n < bound) begin
            cycle();
            n++;
        end
        check("idle_timeout", 32'(m_pulses >= FRAME_TICKS), 32'd1);
    endtask

    initial begin
        int exp_order[4];
        int prev;
        exp_order = '{0, 1, 2, 0};

        // Reset
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);

        // Single frame, requester 1 sends 0xA5, tick every 10 clk
        tick_per = 10;
        req_data[15:8] = 8'hA5;
        req_valid = 3'b010;
        wait_accept(acc_cnt + 1, 50);
        req_valid = '0;
        check("t1_grant", 32'(grant_id), 32'd1);
        wait_idle(2000);

        // Contention from ptr 0
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        tick_per = 2;
        req_data = {8'h33, 8'h22, 8'h11};
        req_valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_accept(acc_cnt + 1, 400);
            check("cont_order", 32'(grant_id), 32'(exp_order[i]));
        end
        req_valid = '0;
        wait_idle(400);

        // Pointer wrap: grant 2, then only 0 and 2 valid
        req_valid = 3'b100;
        wait_accept(acc_cnt + 1, 50);
        check("wrap_g2", 32'(grant_id), 32'd2);
        req_valid = 3'b101;
        wait_idle(400);
        wait_accept(acc_cnt + 1, 50);
        check("wrap_g0", 32'(grant_id), 32'd0);
        req_valid = '0;
        wait_idle(400);

        // Back-to-back from requester 0
        tick_per = 3;
        req_data[7:0] = 8'h3C;
        req_valid = 3'b001;
        wait_accept(acc_cnt + 1, 50);
        req_data[7:0] = 8'hC3;
        wait_idle(600);
        prev = acc_cnt;
        cycle();
        check("b2b_accept", 32'(acc_cnt), 32'(prev + 1));
        check("b2b_busy", 32'(busy), 32'd1);
        req_valid = '0;
        wait_idle(600);

        // Mid-frame reset during data bit 4
        tick_per = 2;
        req_data[15:8] = 8'($urandom);
        req_valid = 3'b010;
        wait_accept(acc_cnt + 1, 50);
        req_valid = '0;
        while (m_pulses < 84) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mrst_tx", 32'(tx), 32'd1);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_grant", 32'(grant_id), 32'd0);
        req_data[23:16] = 8'($urandom);
        req_valid = 3'b100;
        wait_accept(acc_cnt + 1, 50);
        req_valid = '0;
        check("mrst_g2", 32'(grant_id), 32'd2);
        wait_idle(400);

        // Idle hold with ticks running
        tick_per = 10;
        repeat (5000) cycle();

        // Randomized traffic
        for (int it = 0; it < 10; it++) begin
            tick_per = int'($urandom_range(1, 4));
            req_data = {8'($urandom), 8'($urandom), 8'($urandom)};
            req_valid = 3'($urandom_range(1, 7));
            wait_accept(acc_cnt + 1, 50);
            req_valid = 3'($urandom_range(0, 7));
            repeat (int'($urandom_range(0, 40))) cycle();
            req_valid = '0;
            wait_idle(800);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
